upstream_packetizer: RTL and testbench

UPSTREAM_PACKETIZER -- requirements
Module: upstream_packetizer

---
 rtl/upstream_packetizer_pkg.sv | 34 +++
 rtl/upstream_packetizer_fifo.sv | 52 +++++
 rtl/upstream_packetizer.sv | 168 ++++++++++++++++
 tb/tb_upstream_packetizer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upstream_packetizer_pkg.sv
// Shared constants for the upstream packetizer: packet field layout, FSM state
// encodings and the credit counter width.
`timescale 1ns/1ps
package upstream_packetizer_pkg;

    localparam int unsigned PKT_PAYLOAD_LSB = 0;
    localparam int unsigned PKT_PAYLOAD_W   = 32;
    localparam int unsigned PKT_ADDR_LSB    = 32;
    localparam int unsigned PKT_ADDR_W      = 7;
    localparam int unsigned PKT_PORT_LSB    = 39;
    localparam int unsigned PKT_PORT_W      = 4;
    localparam int unsigned PKT_LEAF_LSB    = 43;
    localparam int unsigned PKT_LEAF_W      = 5;
    localparam int unsigned PKT_VALID_BIT   = 48;
    localparam int unsigned PKT_W           = PKT_VALID_BIT + 1;

    // One extra bit so the full receiver buffer (2^addr) is representable.
    localparam int unsigned CREDIT_W = PKT_ADDR_W + 1;

    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_UNCFG  = 2'd0;
    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd1;
    localparam logic [STATE_W-1:0] ST_SEND   = 2'd2;
    localparam logic [STATE_W-1:0] ST_CRWAIT = 2'd3;

    typedef struct packed {
        logic                     valid;
        logic [PKT_LEAF_W-1:0]    leaf;
        logic [PKT_PORT_W-1:0]    port;
        logic [PKT_ADDR_W-1:0]    addr;
        logic [PKT_PAYLOAD_W-1:0] payload;
    } pkt_t;

endpackage

// File: rtl/upstream_packetizer_fifo.sv
// Small synchronous FIFO with occupancy count; head word is visible combinationally.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [CNT_W-1:0] count_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    // A write and a read on an empty FIFO pass straight through: both pointers advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    assign rd_data_c = mem[rd_ptr_q];
    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign empty_c   = (count_q == '0);
    assign count_c   = count_q;

endmodule

// File: rtl/upstream_packetizer.sv
// Packs user words into BFT packets with destination, slot address and
// credit-based flow control toward the receiver buffer.
`timescale 1ns/1ps
module upstream_packetizer
    import upstream_packetizer_pkg::*;
#(
    parameter int unsigned PACKET_BITS           = 49,
    parameter int unsigned PAYLOAD_BITS          = 32,
    parameter int unsigned NUM_LEAF_BITS         = 5,
    parameter int unsigned NUM_PORT_BITS         = 4,
    parameter int unsigned NUM_ADDR_BITS         = 7,
    parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
    parameter int unsigned FIFO_DEPTH            = 4
) (
    input  logic                     clk_user,
    input  logic                     reset,
    input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
    input  logic                     vld_user2interface,
    output logic                     ack_interface2user,
    input  logic                     cfg_vld,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dst_port,
    input  logic                     freespace_upd,
    output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
    input  logic                     pkt_grant,
    output logic [NUM_ADDR_BITS:0]   credits,
    output logic                     credit_err
);

    localparam int unsigned CRED_W     = NUM_ADDR_BITS + 1;
    localparam int unsigned SUM_W      = CRED_W + 1;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = {1'b1, {NUM_ADDR_BITS{1'b0}}};

    logic [STATE_W-1:0]       state_q,      state_d;
    logic [NUM_LEAF_BITS-1:0] dst_leaf_q,   dst_leaf_d;
    logic [NUM_PORT_BITS-1:0] dst_port_q,   dst_port_d;
    logic                     pkt_valid_q,  pkt_valid_d;
    logic [NUM_LEAF_BITS-1:0] pkt_leaf_q,   pkt_leaf_d;
    logic [NUM_PORT_BITS-1:0] pkt_port_q,   pkt_port_d;
    logic [NUM_ADDR_BITS-1:0] pkt_addr_q,   pkt_addr_d;
    logic [PAYLOAD_BITS-1:0]  pkt_data_q,   pkt_data_d;
    logic [NUM_ADDR_BITS-1:0] addr_cnt_q,   addr_cnt_d;
    logic [CRED_W-1:0]        credits_q,    credits_d;
    logic                     credit_err_q, credit_err_d;

    logic                    fifo_full_c;
    logic                    fifo_empty_c;
    logic [PAYLOAD_BITS-1:0] fifo_head_c;
    logic [FIFO_CNT_W-1:0]   fifo_count_c;
    logic [FIFO_CNT_W-1:0]   fifo_level_c;
    logic                    accept_c;
    logic                    avail_c;
    logic                    load_c;
    logic [PAYLOAD_BITS-1:0] load_word_c;
    logic [SUM_W-1:0]        cred_sum_c;

    sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FIFO_CNT_W)
    ) u_fifo (
        .clk       (clk_user),
        .rst_n     (reset),
        .wr_en     (accept_c),
        .wr_data   (din_leaf_user2interface),
        .rd_en     (load_c),
        .rd_data_c (fifo_head_c),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c),
        .count_c   (fifo_count_c)
    );

    // Ack depends only on registered state, so it reflects the pre-read full condition.
    assign ack_interface2user = (state_q != ST_UNCFG) && !fifo_full_c;
    assign accept_c    = vld_user2interface && ack_interface2user;
    // An empty FIFO forwards the word being accepted so the packet shows up one cycle later.
    assign avail_c     = !fifo_empty_c || accept_c;
    assign load_word_c = fifo_empty_c ? din_leaf_user2interface : fifo_head_c;
    assign load_c      = avail_c && (credits_q != '0) && (!pkt_valid_q || pkt_grant);
    assign cred_sum_c  = SUM_W'(credits_q)
                       + (freespace_upd ? SUM_W'(FREESPACE_UPDATE_SIZE) : SUM_W'(0))
                       - SUM_W'(load_c);
    assign fifo_level_c = fifo_count_c + FIFO_CNT_W'(accept_c) - FIFO_CNT_W'(load_c);

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_UNCFG;
            dst_leaf_q   <= '0;
            dst_port_q   <= '0;
            pkt_valid_q  <= 1'b0;
            pkt_leaf_q   <= '0;
            pkt_port_q   <= '0;
            pkt_addr_q   <= '0;
            pkt_data_q   <= '0;
            addr_cnt_q   <= '0;
            credits_q    <= CRED_MAX;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dst_leaf_q   <= dst_leaf_d;
            dst_port_q   <= dst_port_d;
            pkt_valid_q  <= pkt_valid_d;
            pkt_leaf_q   <= pkt_leaf_d;
            pkt_port_q   <= pkt_port_d;
            pkt_addr_q   <= pkt_addr_d;
            pkt_data_q   <= pkt_data_d;
            addr_cnt_q   <= addr_cnt_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dst_leaf_d   = dst_leaf_q;
        dst_port_d   = dst_port_q;
        pkt_valid_d  = pkt_valid_q;
        pkt_leaf_d   = pkt_leaf_q;
        pkt_port_d   = pkt_port_q;
        pkt_addr_d   = pkt_addr_q;
        pkt_data_d   = pkt_data_q;
        addr_cnt_d   = addr_cnt_q;
        credits_d    = credits_q;
        credit_err_d = credit_err_q;

        // New destination only affects packets loaded after this cycle.
        if (cfg_vld) begin
            dst_leaf_d = cfg_dst_leaf;
            dst_port_d = cfg_dst_port;
        end

        if (load_c) begin
            pkt_valid_d = 1'b1;
            pkt_leaf_d  = dst_leaf_q;
            pkt_port_d  = dst_port_q;
            pkt_addr_d  = addr_cnt_q;
            pkt_data_d  = load_word_c;
            addr_cnt_d  = addr_cnt_q + 1'b1;
        end else if (pkt_grant) begin
            pkt_valid_d = 1'b0;
        end

        if (cred_sum_c > SUM_W'(CRED_MAX)) begin
            credits_d    = CRED_MAX;
            credit_err_d = 1'b1;
        end else begin
            credits_d = cred_sum_c[CRED_W-1:0];
        end

        case (state_q)
            ST_UNCFG: begin
                if (cfg_vld) state_d = ST_IDLE;
            end
            default: begin
                if (pkt_valid_d)                                state_d = ST_SEND;
                else if (fifo_level_c != '0 && credits_d == '0) state_d = ST_CRWAIT;
                else                                            state_d = ST_IDLE;
            end
        endcase
    end

    assign dout_leaf_interface2bft = PACKET_BITS'({pkt_valid_q, pkt_leaf_q, pkt_port_q,
                                                   pkt_addr_q, pkt_data_q});
    assign credits    = credits_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_upstream_packetizer.sv
// Directed bench for upstream_packetizer: table of single-packet vectors plus
// hand-written credit, back-pressure and reset sequences.
`timescale 1ns/1ps
module tb_upstream_packetizer;
    import upstream_packetizer_pkg::*;

    logic        clk_user = 1'b0;
    logic        reset    = 1'b0;
    logic [31:0] din      = '0;
    logic        vld      = 1'b0;
    logic        ack;
    logic        cfg_vld  = 1'b0;
    logic [4:0]  cfg_leaf = '0;
    logic [3:0]  cfg_port = '0;
    logic        fs_upd   = 1'b0;
    logic [48:0] dout;
    logic        grant    = 1'b0;
    logic [7:0]  credits;
    logic        credit_err;

    int n_cmp = 0;
    int n_err = 0;
    int acc;
    logic [48:0] held;
    pkt_t        p;

    always #5 clk_user = ~clk_user;

    upstream_packetizer dut (
        .clk_user                (clk_user),
        .reset                   (reset),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .cfg_vld                 (cfg_vld),
        .cfg_dst_leaf            (cfg_leaf),
        .cfg_dst_port            (cfg_port),
        .freespace_upd           (fs_upd),
        .dout_leaf_interface2bft (dout),
        .pkt_grant               (grant),
        .credits                 (credits),
        .credit_err              (credit_err)
    );

    typedef struct {
        logic        cfg_en;
        logic [4:0]  leaf;
        logic [3:0]  port;
        logic [31:0] word;
        logic [48:0] exp_pkt;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_user);
        #1;
    endtask

    task automatic apply_cfg(input logic [4:0] l, input logic [3:0] pt);
        cfg_leaf = l;
        cfg_port = pt;
        cfg_vld  = 1'b1;
        tick();
        cfg_vld  = 1'b0;
    endtask

    task automatic do_reset();
        vld = 1'b0; grant = 1'b0; fs_upd = 1'b0; cfg_vld = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Offers n_words with grant held high; checks each packet's address and payload.
    task automatic send_stream(input int n_words, input int exp_pkts, input logic [31:0] base);
        int   a   = 0;
        int   o   = 0;
        int   cyc = 0;
        pkt_t q;
        grant = 1'b1;
        while ((a < n_words || o < exp_pkts) && cyc < 1000) begin
            vld = (a < n_words);
            din = base + 32'(a);
            q   = dout;
            if (q.valid) begin
                check("stream_addr", 64'(q.addr), 64'((o % 128)));
                check("stream_payload", 64'(q.payload), 64'(base + 32'(o)));
                o++;
            end
            if (vld && ack) a++;
            tick();
            cyc++;
        end
        vld = 1'b0;
        check("stream_words", 64'(a), 64'(n_words));
        check("stream_pkts", 64'(o), 64'(exp_pkts));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5,  4'd3,  32'hDEADBEEF, 49'h1_2980_DEADBEEF};
        vecs[1] = '{1'b0, 5'd5,  4'd3,  32'h00000001, 49'h1_2981_00000001};
        vecs[2] = '{1'b1, 5'd31, 4'd15, 32'hFFFFFFFF, 49'h1_FF82_FFFFFFFF};
        vecs[3] = '{1'b1, 5'd0,  4'd0,  32'h12345678, 49'h1_0003_12345678};
        vecs[4] = '{1'b1, 5'd10, 4'd9,  32'hA5A5A5A5, 49'h1_5484_A5A5A5A5};

        // Reset values, with a word already offered.
        vld = 1'b1;
        din = 32'h11111111;
        tick();
        tick();
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_credits", 64'(credits), 64'd128);
        check("rst_err", 64'(credit_err), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_state", 64'(dut.state_q), 64'(ST_UNCFG));
        reset = 1'b1;
        tick();
        check("uncfg_ack", 64'(ack), 64'd0);
        check("uncfg_valid", 64'(dout[48]), 64'd0);
        vld = 1'b0;

        // Single-word vectors: one-cycle latency, field placement, cfg changes.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].cfg_en) apply_cfg(vecs[i].leaf, vecs[i].port);
            din   = vecs[i].word;
            vld   = 1'b1;
            grant = 1'b1;
            check($sformatf("vec%0d_ack", i), 64'(ack), 64'd1);
            tick();
            vld = 1'b0;
            check($sformatf("vec%0d_pkt", i), 64'(dout), 64'(vecs[i].exp_pkt));
            tick();
            check($sformatf("vec%0d_drained", i), 64'(dout[48]), 64'd0);
        end
        check("vec_credits", 64'(credits), 64'd123);

        // Exhaust all 128 credits; the surplus words fill the FIFO.
        do_reset();
        apply_cfg(5'd2, 4'd1);
        send_stream(132, 128, 32'h1000);
        check("crw_credits", 64'(credits), 64'd0);
        check("crw_state", 64'(dut.state_q), 64'(ST_CRWAIT));
        check("crw_valid", 64'(dout[48]), 64'd0);
        check("crw_ack", 64'(ack), 64'd0);

        // One credit update, then step two packets out across the address wrap.
        grant  = 1'b0;
        fs_upd = 1'b1;
        tick();
        fs_upd = 1'b0;
        check("upd_credits", 64'(credits), 64'd64);
        tick();
        p = dout;
        check("wrap0_valid", 64'(p.valid), 64'd1);
        check("wrap0_addr", 64'(p.addr), 64'd0);
        check("wrap0_payload", 64'(p.payload), 64'h1080);
        check("wrap0_credits", 64'(credits), 64'd63);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        p = dout;
        check("wrap1_addr", 64'(p.addr), 64'd1);
        check("wrap1_payload", 64'(p.payload), 64'h1081);
        check("wrap1_credits", 64'(credits), 64'd62);
        tick();
        check("wrap1_hold_addr", 64'(dout[38:32]), 64'd1);
        check("wrap1_hold_credits", 64'(credits), 64'd62);
        grant = 1'b1;
        tick();
        p = dout;
        check("drain_a2", 64'(p.addr), 64'd2);
        check("drain_p2", 64'(p.payload), 64'h1082);
        tick();
        p = dout;
        check("drain_a3", 64'(p.addr), 64'd3);
        check("drain_p3", 64'(p.payload), 64'h1083);
        tick();
        check("drain_idle", 64'(dout[48]), 64'd0);
        check("drain_credits", 64'(credits), 64'd60);

        // Back-pressure: packet held for 10 cycles, cfg changed mid-hold.
        grant = 1'b0;
        vld   = 1'b1;
        din   = 32'hA000;
        tick();
        held = dout;
        check("hold_pkt", 64'(held), 64'(49'h1_1084_0000A000));
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            din      = 32'hA001 + 32'(acc);
            cfg_vld  = (c == 2);
            cfg_leaf = 5'd7;
            cfg_port = 4'd6;
            if (ack) acc++;
            tick();
            check("hold_stable", 64'(dout), 64'(held));
        end
        vld     = 1'b0;
        cfg_vld = 1'b0;
        check("hold_accepted", 64'(acc), 64'd4);
        check("hold_ack", 64'(ack), 64'd0);
        grant = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            p = dout;
            check("post_valid", 64'(p.valid), 64'd1);
            check("post_leaf", 64'(p.leaf), 64'd7);
            check("post_port", 64'(p.port), 64'd6);
            check("post_addr", 64'(p.addr), 64'(5 + k));
            check("post_payload", 64'(p.payload), 64'(32'hA001 + 32'(k)));
        end
        tick();
        check("post_idle", 64'(dout[48]), 64'd0);
        check("post_credits", 64'(credits), 64'd55);

        // Load and credit update in the same cycle: net +63.
        vld    = 1'b1;
        din    = 32'hB000;
        fs_upd = 1'b1;
        tick();
        vld    = 1'b0;
        fs_upd = 1'b0;
        check("same_cyc_credits", 64'(credits), 64'd118);
        check("same_cyc_addr", 64'(dout[38:32]), 64'd9);
        check("same_cyc_err", 64'(credit_err), 64'd0);
        tick();

        // Overflow: update at 100 credits clamps to 128 and sets the sticky flag.
        do_reset();
        apply_cfg(5'd1, 4'd1);
        send_stream(28, 28, 32'hC000);
        check("ovf_pre_credits", 64'(credits), 64'd100);
        fs_upd = 1'b1;
        tick();
        fs_upd = 1'b0;
        check("ovf_credits", 64'(credits), 64'd128);
        check("ovf_err", 64'(credit_err), 64'd1);
        tick();
        check("ovf_err_sticky", 64'(credit_err), 64'd1);

        // Reset with three words queued discards them; nothing appears before cfg.
        grant = 1'b0;
        acc   = 0;
        for (int c = 0; c < 10 && acc < 3; c++) begin
            vld = 1'b1;
            din = 32'hD000 + 32'(acc);
            if (ack) acc++;
            tick();
        end
        vld = 1'b0;
        check("q3_accepted", 64'(acc), 64'd3);
        check("q3_valid", 64'(dout[48]), 64'd1);
        #3;
        reset = 1'b0;
        #1;
        check("arst_valid", 64'(dout[48]), 64'd0);
        check("arst_credits", 64'(credits), 64'd128);
        check("arst_err", 64'(credit_err), 64'd0);
        check("arst_ack", 64'(ack), 64'd0);
        tick();
        reset = 1'b1;
        grant = 1'b1;
        vld   = 1'b1;
        din   = 32'hEEEE0000;
        for (int c = 0; c < 6; c++) begin
            check("nocfg_ack", 64'(ack), 64'd0);
            tick();
            check("nocfg_valid", 64'(dout[48]), 64'd0);
        end
        vld = 1'b0;
        apply_cfg(5'd3, 4'd2);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("flushed_valid", 64'(dout[48]), 64'd0);
        end
        vld = 1'b1;
        din = 32'hE000;
        tick();
        vld = 1'b0;
        check("first_after_rst", 64'(dout), 64'(49'h1_1900_0000E000));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
